// File: rtl/host_tx_arbiter.sv
// rtl/host_tx_arbiter.sv - round-robin burst arbiter sharing the host write FIFO
module host_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 2500000,
    parameter int CNT_W   = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   abort,
    output logic                 wr_en,
    output logic [7:0]           wr_data,
    input  logic                 wr_full,
    output logic                 busy,
    output logic [7:0]           timeout_count
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] winner;
    logic [CNT_W-1:0] cnt;
    int               scan_j;
    logic [IDX_W-1:0] scan_idx;
    logic             owner_valid;
    logic             owner_last;
    logic             owner_ack;
    logic [7:0]       owner_data;
    logic             accept;

    // Scan downwards so the lowest offset from ptr is written last and wins.
    always_comb begin
        winner   = ptr;
        scan_j   = 0;
        scan_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_j   = (int'(ptr) + k) % NUM_REQ;
            scan_idx = IDX_W'(scan_j);
            if (req_valid[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_ack   = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_ack   = req_ack[i];
                owner_data  = req_data[8*i +: 8];
            end
        end
    end

    assign owner_next = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // The registered ack blocks a second accept right after a write, giving the
    // requester one cycle to advance its lane and the FIFO time to flag full.
    assign accept = (state == BURST) && owner_valid && !wr_full && !owner_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            timeout_count <= 8'h00;
            grant         <= '0;
            req_ack       <= '0;
            abort         <= '0;
            wr_en         <= 1'b0;
            wr_data       <= 8'h00;
            busy          <= 1'b0;
        end else begin
            req_ack <= '0;
            abort   <= '0;
            wr_en   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|req_valid) begin
                        owner <= winner;
                        grant <= NUM_REQ'(1) << winner;
                        busy  <= 1'b1;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_data <= owner_data;
                        req_ack <= NUM_REQ'(1) << owner;
                        cnt     <= '0;
                        if (owner_last) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            ptr   <= owner_next;
                            state <= IDLE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        abort <= NUM_REQ'(1) << owner;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                        cnt   <= '0;
                        state <= IDLE;
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
